// File: rtl/mem_subsystem.sv
// Dual-port memory subsystem: instruction port serves IMEM, data port serves DMEM plus
// a small MMIO register file. Each memory has a background clear engine.
module mem_subsystem #(
  parameter int          IMEM_DEPTH = 512,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h0010_0000,
  parameter int          N_MMIO     = 5,
  parameter logic [31:0] ID_VALUE   = 32'd11685268
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_clr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  output logic        i_busy,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_clr,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        d_busy,
  output logic [31:0] mmio_out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int MAW = $clog2(N_MMIO);
  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(4 * IMEM_DEPTH) - 32'd4;
  localparam logic [31:0] DMEM_LAST = DMEM_BASE + 32'(4 * DMEM_DEPTH) - 32'd4;
  localparam logic [31:0] MMIO_LAST = MMIO_BASE + 32'(4 * N_MMIO) - 32'd4;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] mmio_regs [N_MMIO];

  clr_state_e i_state, d_state;
  logic [IAW-1:0] i_cnt, i_idx;
  logic [DAW-1:0] d_cnt, d_idx;
  logic [MAW-1:0] m_idx;
  logic i_hit, i_bad, d_hit_mem, d_hit_mmio, d_blk, d_bad;
  logic [31:0] mmio_rd;

  // A memory is unavailable while clearing and also in the cycle its clr is sampled.
  assign i_hit = (i_addr >= IMEM_BASE) && (i_addr <= IMEM_LAST);
  assign i_idx = IAW'((i_addr - IMEM_BASE) >> 2);
  assign i_bad = (i_addr[1:0] != 2'b00) || !i_hit || (i_state == CLEAR) || i_clr;

  assign d_hit_mem  = (d_addr >= DMEM_BASE) && (d_addr <= DMEM_LAST);
  assign d_hit_mmio = (d_addr >= MMIO_BASE) && (d_addr <= MMIO_LAST);
  assign d_idx      = DAW'((d_addr - DMEM_BASE) >> 2);
  assign m_idx      = MAW'((d_addr - MMIO_BASE) >> 2);
  assign d_blk      = (d_state == CLEAR) || d_clr;
  assign d_bad      = (d_addr[1:0] != 2'b00) || !(d_hit_mem || d_hit_mmio) ||
                      (d_hit_mem && d_blk) || (d_hit_mmio && d_we && (m_idx == '0));
  assign mmio_rd    = (m_idx == '0) ? ID_VALUE : mmio_regs[m_idx];
  assign mmio_out   = mmio_regs[N_MMIO-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_state <= IDLE;
      i_cnt   <= '0;
      i_busy  <= 1'b0;
    end else begin
      case (i_state)
        IDLE: if (i_clr) begin
          i_state <= CLEAR;
          i_cnt   <= '0;
          i_busy  <= 1'b1;
        end
        CLEAR: begin
          i_cnt <= i_cnt + 1'b1;
          if (i_cnt == IAW'(IMEM_DEPTH - 1)) begin
            i_state <= IDLE;
            i_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= IDLE;
      d_cnt   <= '0;
      d_busy  <= 1'b0;
    end else begin
      case (d_state)
        IDLE: if (d_clr) begin
          d_state <= CLEAR;
          d_cnt   <= '0;
          d_busy  <= 1'b1;
        end
        CLEAR: begin
          d_cnt <= d_cnt + 1'b1;
          if (d_cnt == DAW'(DMEM_DEPTH - 1)) begin
            d_state <= IDLE;
            d_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Arrays have no reset; a reset only stops the clear engines from writing further.
  always_ff @(posedge clk) begin
    if (i_state == CLEAR)
      imem[i_cnt] <= '0;
    else if (rst_n && i_req && i_we && !i_bad)
      imem[i_idx] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (d_state == CLEAR)
      dmem[d_cnt] <= '0;
    else if (rst_n && d_req && d_we && !d_bad && d_hit_mem)
      dmem[d_idx] <= d_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= '0;
      i_valid <= 1'b0;
      i_err   <= 1'b0;
    end else begin
      i_valid <= i_req && !i_bad;
      i_err   <= i_req && i_bad;
      if (i_req && !i_bad && !i_we)
        i_rdata <= imem[i_idx];
    end
  end

  // Register 0 is never written because such a write is flagged as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata <= '0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      for (int k = 0; k < N_MMIO; k++)
        mmio_regs[k] <= '0;
    end else begin
      d_valid <= d_req && !d_bad;
      d_err   <= d_req && d_bad;
      if (d_req && !d_bad) begin
        if (d_we) begin
          if (d_hit_mmio)
            mmio_regs[m_idx] <= d_wdata;
        end else begin
          d_rdata <= d_hit_mmio ? mmio_rd : dmem[d_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem: decode, errors, MMIO, clear engines and reset-abort.
module tb_mem_subsystem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_we, i_clr, d_req, d_we, d_clr;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mmio_out;
  logic        i_valid, i_err, i_busy, d_valid, d_err, d_busy;

  int total = 0;
  int bad = 0;
  int busy_cycles;

  mem_subsystem dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_clr(i_clr),
    .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err), .i_busy(i_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_clr(d_clr),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .d_busy(d_busy),
    .mmio_out(mmio_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One-cycle request on the chosen port; returns at the negedge where the response is visible.
  task automatic applyStimulus(input bit on_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    if (on_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
    end
    @(negedge clk);
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {i_req, i_we, i_clr, d_req, d_we, d_clr} = '0;
    {i_addr, i_wdata, d_addr, d_wdata} = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_flags", {26'd0, i_valid, i_err, i_busy, d_valid, d_err, d_busy}, 32'h0);
    checkOutput("rst_mmio_out", mmio_out, 32'h0);
    rst_n = 1'b1;

    // Data write then read-back
    applyStimulus(1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    checkOutput("dwr_valid", {30'd0, d_valid, d_err}, 32'h2);
    checkOutput("dwr_rdata_hold", d_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0010, 32'h0);
    checkOutput("drd_valid", {30'd0, d_valid, d_err}, 32'h2);
    checkOutput("drd_rdata", d_rdata, 32'hDEAD_BEEF);

    // Instruction window edges and misalignment
    applyStimulus(1'b0, 1'b1, 32'h0100_07FC, 32'h1234_5678);
    checkOutput("iwr_last_valid", {30'd0, i_valid, i_err}, 32'h2);
    applyStimulus(1'b0, 1'b0, 32'h0100_07FC, 32'h0);
    checkOutput("ird_last", i_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0100_0002, 32'h0);
    checkOutput("imis_flags", {30'd0, i_valid, i_err}, 32'h1);
    checkOutput("imis_rdata_hold", i_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, 32'h0100_0800, 32'hFFFF_FFFF);
    checkOutput("iout_flags", {30'd0, i_valid, i_err}, 32'h1);
    checkOutput("iout_rdata_hold", i_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0100_07FC, 32'h0);
    checkOutput("iout_no_write", i_rdata, 32'h1234_5678);

    // Data window edges
    applyStimulus(1'b1, 1'b0, 32'h8000_1000, 32'h0);
    checkOutput("dout_hi_flags", {30'd0, d_valid, d_err}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0);
    checkOutput("dout_lo_flags", {30'd0, d_valid, d_err}, 32'h1);
    checkOutput("dout_rdata_hold", d_rdata, 32'hDEAD_BEEF);

    // MMIO: ID register, read-only write, last register
    applyStimulus(1'b1, 1'b0, 32'h0010_0000, 32'h0);
    checkOutput("mmio_id", d_rdata, 32'd11685268);
    applyStimulus(1'b1, 1'b1, 32'h0010_0000, 32'h0000_0007);
    checkOutput("mmio_id_wr_err", {30'd0, d_valid, d_err}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h0010_0010, 32'h0000_0005);
    checkOutput("mmio_out_5", mmio_out, 32'h5);
    applyStimulus(1'b1, 1'b0, 32'h0010_0010, 32'h0);
    checkOutput("mmio_rd_4", d_rdata, 32'h5);
    applyStimulus(1'b1, 1'b0, 32'h0010_0014, 32'h0);
    checkOutput("mmio_out_range", {30'd0, d_valid, d_err}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0010_0000, 32'h0);
    checkOutput("mmio_id_again", d_rdata, 32'd11685268);

    // IMEM clear: request in the clr cycle and during busy both error; a second clr is ignored
    applyStimulus(1'b0, 1'b1, 32'h0100_000C, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 1'b0, 32'h0100_000C, 32'h0);
    checkOutput("iword3_before", i_rdata, 32'hA5A5_A5A5);
    @(negedge clk);
    i_clr = 1'b1; i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0100_000C;
    busy_cycles = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("iclr_cycle_err", {30'd0, i_valid, i_err}, 32'h1);
        i_clr = 1'b0;
      end
      if (k == 2) begin
        checkOutput("ibusy_req_err", {30'd0, i_valid, i_err}, 32'h1);
        i_req = 1'b0;
      end
      if (k == 100) i_clr = 1'b1;
      if (k == 101) i_clr = 1'b0;
      if (i_busy) busy_cycles++;
      else break;
    end
    checkOutput("ibusy_cycles", busy_cycles, 32'd512);
    applyStimulus(1'b0, 1'b0, 32'h0100_000C, 32'h0);
    checkOutput("iword3_cleared", {i_rdata[31:2], i_valid, i_err}, 32'h2);
    checkOutput("iword3_rdata", i_rdata, 32'h0);

    // DMEM clear aborted by reset once the counter reaches 100
    applyStimulus(1'b1, 1'b1, 32'h8000_00C8, 32'h5050_5050);
    applyStimulus(1'b1, 1'b1, 32'h8000_0320, 32'h2020_2020);
    @(negedge clk);
    d_clr = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      d_clr = 1'b0;
      d_req = 1'b0;
      if (k == 5) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0010_0010;
      end
      if (k == 6) begin
        checkOutput("mmio_during_clear", {d_rdata[31:2], d_valid, d_err}, 32'h6);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0010;
      end
      if (k == 7) checkOutput("dbusy_req_err", {30'd0, d_valid, d_err}, 32'h1);
    end
    checkOutput("dbusy_before_rst", {31'd0, d_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("dbusy_async_rst", {31'd0, d_busy}, 32'h0);
    checkOutput("mmio_rst", mmio_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h8000_00C8, 32'h0);
    checkOutput("dword50_cleared", d_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0320, 32'h0);
    checkOutput("dword200_kept", d_rdata, 32'h2020_2020);
    checkOutput("dbusy_after", {31'd0, d_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
